// File: rtl/stream_memory.sv
// Single-port synchronous RAM with a direct port and a streaming burst-read engine.
// Optional MEM_BURST_STRIDE_EN adds a per-burst address stride input (default stride 1).
module stream_memory #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  input  logic              burst_start,
  input  logic [ADDR_W-1:0] burst_base,
  input  logic [LEN_W-1:0]  burst_len,
`ifdef MEM_BURST_STRIDE_EN
  input  logic [ADDR_W-1:0] burst_stride,
`endif
  output logic              burst_busy,
  output logic              burst_done,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [DATA_W-1:0] s_data,
  output logic              s_last
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        iss_cnt_q, iss_cnt_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    rd_last_q, rd_last_d;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d;
  logic [1:0][DATA_W-1:0]  fifo_data_q, fifo_data_d;
  logic [1:0]              fifo_last_q, fifo_last_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic [DATA_W-1:0]       q_q, q_d;
  logic [ADDR_W-1:0]       stride_w;
  logic                    pop, issue;
  logic [2:0]              occ;

`ifdef MEM_BURST_STRIDE_EN
  logic [ADDR_W-1:0] stride_q, stride_d;
  assign stride_w = stride_q;
`else
  assign stride_w = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

  assign s_valid    = (cnt_q != 2'd0);
  assign s_data     = fifo_data_q[rd_ptr_q];
  assign s_last     = s_valid & fifo_last_q[rd_ptr_q];
  assign burst_busy = (state_q != IDLE);
  assign burst_done = done_q;
  assign q          = q_q;

  always_ff @(posedge clock) begin
    if (wren) mem[address] <= data;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    iss_cnt_d   = iss_cnt_q;
    done_d      = 1'b0;
    rd_last_d   = 1'b0;
    rd_data_d   = rd_data_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
`ifdef MEM_BURST_STRIDE_EN
    stride_d    = stride_q;
`endif
    pop = s_valid && s_ready;
    // Credit check counts the beat leaving this cycle so full-rate streaming has no bubbles.
    occ      = {1'b0, cnt_q} + {2'b0, rd_vld_q} - {2'b0, pop};
    issue    = (state_q == ISSUE) && !wren && (occ < 3'd2);
    rd_vld_d = issue;

    case (state_q)
      IDLE: begin
        if (burst_start && !done_q) begin
          if (burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = ISSUE;
            addr_d    = burst_base;
            len_d     = burst_len;
            iss_cnt_d = '0;
`ifdef MEM_BURST_STRIDE_EN
            stride_d  = burst_stride;
`endif
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          rd_data_d = mem[addr_q];
          addr_d    = addr_q + stride_w;
          iss_cnt_d = iss_cnt_q + 1'b1;
          if (iss_cnt_d == len_q) begin
            rd_last_d = 1'b1;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && s_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_vld_q) begin
      fifo_data_d[wr_ptr_q] = rd_data_q;
      fifo_last_d[wr_ptr_q] = rd_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};

    q_d = wren ? q_q : mem[address];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      iss_cnt_q   <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      fifo_data_q <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      q_q         <= '0;
`ifdef MEM_BURST_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      iss_cnt_q   <= iss_cnt_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      q_q         <= q_d;
`ifdef MEM_BURST_STRIDE_EN
      stride_q    <= stride_d;
`endif
    end
  end
endmodule

// File: tb/tb_stream_memory.sv
// Randomized bench for stream_memory: array model of RAM contents, expected beat queue per burst.
module tb_stream_memory;
  localparam int DEPTH = 4096;

  logic        clock, reset;
  logic [11:0] address;
  logic [15:0] data;
  logic        wren;
  logic [15:0] q;
  logic        burst_start;
  logic [11:0] burst_base;
  logic [7:0]  burst_len;
  logic [11:0] burst_stride;
  logic        burst_busy, burst_done;
  logic        s_valid, s_ready, s_last;
  logic [15:0] s_data;

  logic [15:0] mdl [DEPTH];
  int n_chk = 0;
  int n_err = 0;

  stream_memory dut (
    .clock(clock), .reset(reset), .address(address), .data(data), .wren(wren), .q(q),
    .burst_start(burst_start), .burst_base(burst_base), .burst_len(burst_len),
`ifdef MEM_BURST_STRIDE_EN
    .burst_stride(burst_stride),
`endif
    .burst_busy(burst_busy), .burst_done(burst_done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    address = 12'(a); data = d; wren = 1'b1;
    tick();
    wren = 1'b0;
    mdl[a] = d;
  endtask

  task automatic rd_chk(input int a);
    address = 12'(a); wren = 1'b0;
    tick();
    chk("direct_read", q, mdl[a]);
  endtask

  // rdy: percent chance of s_ready per cycle, or 101 for the repeating 1,0,0 pattern.
  task automatic run_burst(input int base, input int len, input int stride, input int rdy,
                           input bit noise, input bit late);
    logic [15:0] exp_q[$];
    logic [15:0] prev_d;
    logic        prev_l;
    int k, cyc, a;
    bit stall, full_rate, done_seen;
    full_rate = (rdy == 100) && !noise && !late;
    for (int i = 0; i < len; i++) exp_q.push_back(mdl[(base + i * stride) % DEPTH]);
    burst_base = 12'(base); burst_len = 8'(len); burst_stride = 12'(stride);
    burst_start = 1'b1; wren = 1'b0; s_ready = 1'b0;
    tick();
    burst_start = 1'b0;
    chk("busy_after_start", burst_busy, 1);
    if (late) begin
      // last beat's address has not been read yet, so the new value must stream out
      a = (base + (len - 1) * stride) % DEPTH;
      address = 12'(a); data = 16'($urandom); wren = 1'b1;
      mdl[a] = data; exp_q[len-1] = data;
      tick();
      wren = 1'b0;
    end
    k = 0; cyc = 0; stall = 0; done_seen = 0; prev_d = '0; prev_l = 1'b0;
    while (cyc < 3000) begin
      if (burst_done) begin done_seen = 1; break; end
      if (stall) begin
        chk("stall_data", s_data, prev_d);
        chk("stall_last", s_last, prev_l);
      end
      s_ready = (rdy == 101) ? (cyc % 3 == 0) : ($urandom_range(99) < rdy);
      wren = 1'b0;
      if (noise && $urandom_range(3) == 0) begin
        a = 2048 + $urandom_range(63);
        address = 12'(a); data = 16'($urandom); wren = 1'b1; mdl[a] = data;
      end
      burst_start = burst_busy && ($urandom_range(7) == 0);
      burst_base = 12'($urandom); burst_len = 8'($urandom_range(9, 1));
      if (full_rate && cyc < 2) chk("no_early_valid", s_valid, 0);
      if (s_valid && s_ready) begin
        if (k < len) begin
          chk("beat_data", s_data, exp_q[k]);
          chk("beat_last", s_last, k == len - 1);
          if (full_rate) chk("beat_cycle", cyc, k + 2);
        end else chk("extra_beat", k, len);
        k++;
      end
      stall = s_valid && !s_ready; prev_d = s_data; prev_l = s_last;
      tick();
      cyc++;
    end
    burst_start = 1'b0; wren = 1'b0;
    chk("burst_done_seen", done_seen, 1);
    chk("beat_count", k, len);
    if (full_rate) chk("done_cycle", cyc, len + 2);
    chk("busy_at_done", burst_busy, 0);
    burst_start = 1'b1; burst_len = 8'd3;
    tick();
    burst_start = 1'b0;
    chk("done_one_pulse", burst_done, 0);
    chk("start_in_done_ignored", burst_busy, 0);
    s_ready = 1'b1;
    tick();
    chk("idle_no_valid", s_valid, 0);
  endtask

  initial begin
    int n, cyc, base, len, stride;
    reset = 1'b1; wren = 1'b0; address = '0; data = '0; burst_start = 1'b0;
    burst_base = '0; burst_len = '0; burst_stride = 12'd1; s_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    #12;
    chk("rst_q", q, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_last", s_last, 0);
    chk("rst_busy", burst_busy, 0);
    chk("rst_done", burst_done, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) wr(i, 16'(i * 11 + 3));
    for (int i = 0; i < 8; i++) begin
      address = 12'(i); wren = 1'b0;
      tick();
      chk("init_read", q, 16'(i * 11 + 3));
    end
    rd_chk(3);
    wr(100, 16'hA5A5);
    chk("q_hold_on_write", q, 16'd36);
    for (int a = 8; a < 1200; a++) wr(a, 16'($urandom));
    for (int a = 4064; a < 4096; a++) wr(a, 16'($urandom));
    for (int i = 0; i < 6; i++) rd_chk($urandom_range(1199));

    run_burst(0, 8, 1, 100, 0, 0);
    wr(4094, 16'd1); wr(4095, 16'd2);
    run_burst(4094, 4, 1, 100, 0, 0);
    run_burst(0, 8, 1, 101, 1, 0);
    run_burst(16, 8, 1, 70, 0, 1);
`ifdef MEM_BURST_STRIDE_EN
    run_burst(0, 4, 2, 100, 0, 0);
`endif

    burst_base = 12'd5; burst_len = 8'd0; burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
    chk("len0_done", burst_done, 1);
    chk("len0_busy", burst_busy, 0);
    chk("len0_valid", s_valid, 0);
    tick();
    chk("len0_done_clear", burst_done, 0);
    chk("len0_no_valid", s_valid, 0);

    // reset after the third beat of a len-8 burst
    burst_base = 12'd0; burst_len = 8'd8; burst_start = 1'b1; s_ready = 1'b1;
    tick();
    burst_start = 1'b0;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 50) begin
      if (s_valid && s_ready) n++;
      tick();
      cyc++;
    end
    chk("rst_test_beats", n, 3);
    reset = 1'b1;
    #1;
    chk("midrst_valid", s_valid, 0);
    chk("midrst_busy", burst_busy, 0);
    chk("midrst_done", burst_done, 0);
    chk("midrst_q", q, 0);
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_valid", s_valid, 0);
      chk("post_rst_done", burst_done, 0);
    end
    address = 12'd5; wren = 1'b0;
    tick();
    chk("ram_kept_after_rst", q, 16'd58);

    for (int it = 0; it < 15; it++) begin
      base = ($urandom_range(3) == 0) ? 4080 + $urandom_range(15) : $urandom_range(1023);
      len  = $urandom_range(24, 1);
`ifdef MEM_BURST_STRIDE_EN
      stride = $urandom_range(3, 1);
`else
      stride = 1;
`endif
      run_burst(base, len, stride, $urandom_range(100, 20), 1'($urandom_range(1)),
                1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
